hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage CPU. It merges stall requests from ID, EX and MEM into a per-stage stall vector, including the `stall` input of the PC register. It times fixed-latency memory/IO accesses with an internal wait FSM. It turns branch resolutions into `branch_flag`/`branch_addr` redirects for the PC register, and holds any redirect that arrives while the PC is stalled so it is never lost.

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_if.sv | 29 ++
 rtl/hazard_ctrl_mem_wait_fsm.sv | 55 +++++
 rtl/hazard_ctrl.sv | 75 +++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared constants for the pipeline hazard controller (stall vectors, wait-FSM codes, ZeroWord).
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Stall vector bits: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 reserved.
  // A stage stalls together with every stage upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // Wait FSM encodings
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Purpose: bundles the pipeline-facing request/redirect signals of hazard_ctrl.
// Latency: n/a (wires only); slave = controller side, master = pipeline side.
// Backpressure: stall vector is the backpressure; no handshake of its own.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic        id_stall_req;
  logic        ex_stall_req;
  logic        mem_start;
  logic        branch_req;
  logic [31:0] branch_target;
  logic [5:0]  stall;
  logic        pc_branch_flag;
  logic [31:0] pc_branch_addr;
  logic        flush;
  logic        mem_busy;
  logic [31:0] stall_count;

  modport slave (
    input  id_stall_req, ex_stall_req, mem_start, branch_req, branch_target,
    output stall, pc_branch_flag, pc_branch_addr, flush, mem_busy, stall_count
  );

  modport master (
    output id_stall_req, ex_stall_req, mem_start, branch_req, branch_target,
    input  stall, pc_branch_flag, pc_branch_addr, flush, mem_busy, stall_count
  );

endinterface

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// Purpose: times a fixed-latency memory/IO access (RUN -> WAIT -> DONE -> RUN).
// Latency: o_mem_stall combinational from i_mem_start; held MEM_WAIT_CYCLES cycles.
// Backpressure: i_mem_start ignored outside S_RUN so a held request cannot retrigger.
// Ports: i_clk, i_rst (sync, active high), i_mem_start; o_mem_stall, o_mem_busy.
module mem_wait_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 2,
  parameter int CNT_W           = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_mem_start,
  output logic o_mem_stall,
  output logic o_mem_busy
);

  localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(MEM_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_mem_start) begin
            // A single-cycle access needs no WAIT phase at all
            if (MEM_WAIT_CYCLES == 1) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= LP_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == LP_ONE) r_state <= S_DONE;
          else                 r_cnt   <= r_cnt - LP_ONE;
        end
        S_DONE:  r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  // First stall cycle comes straight from the request while still in RUN
  assign o_mem_stall = ((r_state == S_RUN) && i_mem_start) || (r_state == S_WAIT);
  assign o_mem_busy  = (r_state == S_WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: merges ID/EX/MEM stall requests into a stall vector and steers branch redirects to the PC.
// Latency: stall/flush/redirect outputs combinational (0 cycles); pend and stall_count registered.
// Backpressure: a redirect seen while the PC is stalled is held in pend until the first unstalled cycle.
// Ports: i_clk, i_rst (sync, active high), hz (hazard_ctrl_if.slave: requests in, stall/redirect out).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 2,
  parameter int CNT_W           = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  hazard_ctrl_if.slave   hz
);

  logic        w_mem_stall;
  logic        w_mem_busy;
  logic [5:0]  w_stall;
  logic        w_flag;
  logic [31:0] w_addr;

  logic        r_pend;
  logic [31:0] r_pend_addr;
  logic [31:0] r_stall_count;

  mem_wait_fsm #(
    .MEM_WAIT_CYCLES (MEM_WAIT_CYCLES),
    .CNT_W           (CNT_W)
  ) u_mem_wait_fsm (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_mem_start (hz.mem_start),
    .o_mem_stall (w_mem_stall),
    .o_mem_busy  (w_mem_busy)
  );

  // Priority mem > ex > id: the deeper stage freezes more of the pipe
  always_comb begin
    w_stall = STALL_NONE;
    if (w_mem_stall)          w_stall = STALL_MEM;
    else if (hz.ex_stall_req) w_stall = STALL_EX;
    else if (hz.id_stall_req) w_stall = STALL_ID;
  end

  // A live request overrides a held one
  assign w_flag = hz.branch_req | r_pend;
  assign w_addr = hz.branch_req ? hz.branch_target : r_pend_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend        <= 1'b0;
      r_pend_addr   <= ZeroWord;
      r_stall_count <= ZeroWord;
    end else begin
      if (w_flag) begin
        if (w_stall[0]) begin
          // PC frozen: keep the newest redirect until it can be taken
          r_pend      <= 1'b1;
          r_pend_addr <= w_addr;
        end else begin
          r_pend      <= 1'b0;
        end
      end
      if (w_stall[0]) r_stall_count <= sat_inc(r_stall_count);
    end
  end

  assign hz.stall          = w_stall;
  assign hz.pc_branch_flag = w_flag;
  assign hz.pc_branch_addr = w_addr;
  assign hz.flush          = w_flag & ~w_stall[0];
  assign hz.mem_busy       = w_mem_busy;
  assign hz.stall_count    = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: self-checking bench for hazard_ctrl with MEM_WAIT_CYCLES = 1, 2 and 3 side by side.
// Latency: outputs compared every unreset cycle at the falling edge against a timeline model.
// Backpressure: n/a (stimulus is free-running).
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_r = 1'b1, ex_r = 1'b1, ms_r = 1'b1, br_r = 1'b1;
  logic [31:0] bt_r = 32'hFFFF_FFFF;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if if_w1 ();
  hazard_ctrl_if if_w2 ();
  hazard_ctrl_if if_w3 ();

  assign if_w1.id_stall_req = id_r;  assign if_w2.id_stall_req = id_r;  assign if_w3.id_stall_req = id_r;
  assign if_w1.ex_stall_req = ex_r;  assign if_w2.ex_stall_req = ex_r;  assign if_w3.ex_stall_req = ex_r;
  assign if_w1.mem_start    = ms_r;  assign if_w2.mem_start    = ms_r;  assign if_w3.mem_start    = ms_r;
  assign if_w1.branch_req   = br_r;  assign if_w2.branch_req   = br_r;  assign if_w3.branch_req   = br_r;
  assign if_w1.branch_target = bt_r; assign if_w2.branch_target = bt_r; assign if_w3.branch_target = bt_r;

  hazard_ctrl #(.MEM_WAIT_CYCLES(1), .CNT_W(4)) dut_w1 (.i_clk(clk), .i_rst(rst), .hz(if_w1));
  hazard_ctrl #(.MEM_WAIT_CYCLES(2), .CNT_W(4)) dut_w2 (.i_clk(clk), .i_rst(rst), .hz(if_w2));
  hazard_ctrl #(.MEM_WAIT_CYCLES(3), .CNT_W(4)) dut_w3 (.i_clk(clk), .i_rst(rst), .hz(if_w3));

  // Index k holds the instance with MEM_WAIT_CYCLES = k+1
  logic [5:0]  o_stall [3];
  logic        o_flag  [3];
  logic [31:0] o_addr  [3];
  logic        o_flush [3];
  logic        o_busy  [3];
  logic [31:0] o_cnt   [3];

  assign o_stall[0] = if_w1.stall;          assign o_stall[1] = if_w2.stall;          assign o_stall[2] = if_w3.stall;
  assign o_flag[0]  = if_w1.pc_branch_flag; assign o_flag[1]  = if_w2.pc_branch_flag; assign o_flag[2]  = if_w3.pc_branch_flag;
  assign o_addr[0]  = if_w1.pc_branch_addr; assign o_addr[1]  = if_w2.pc_branch_addr; assign o_addr[2]  = if_w3.pc_branch_addr;
  assign o_flush[0] = if_w1.flush;          assign o_flush[1] = if_w2.flush;          assign o_flush[2] = if_w3.flush;
  assign o_busy[0]  = if_w1.mem_busy;       assign o_busy[1]  = if_w2.mem_busy;       assign o_busy[2]  = if_w3.mem_busy;
  assign o_cnt[0]   = if_w1.stall_count;    assign o_cnt[1]   = if_w2.stall_count;    assign o_cnt[2]   = if_w3.stall_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An access occupies a window of cycles [t0, t0+W]: stalled for t0..t0+W-1,
  // busy for t0+1..t0+W-1, and a new access may only begin after t0+W.
  int          cyc = 0;
  bit          mvld = 1'b0;
  int          t0      [3];
  logic        pend_m  [3];
  logic [31:0] paddr_m [3];
  logic [31:0] cnt_m   [3];
  int          mw;
  bit          m_act, m_ms, m_busy;
  logic [5:0]  e_stall;
  logic        e_flag, e_flush;
  logic [31:0] e_addr;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      mw = k + 1;
      if (rst) begin
        t0[k]      = -100;
        pend_m[k]  = 1'b0;
        paddr_m[k] = 32'h0;
        cnt_m[k]   = 32'h0;
      end else if (mvld) begin
        m_act = (cyc <= t0[k] + mw);
        if (!m_act && ms_r) begin
          t0[k] = cyc;
          m_act = 1'b1;
        end
        m_ms    = m_act && (cyc <= t0[k] + mw - 1);
        m_busy  = m_act && (cyc >= t0[k] + 1) && (cyc <= t0[k] + mw - 1);
        e_stall = m_ms ? 6'h1F : (ex_r ? 6'h0F : (id_r ? 6'h07 : 6'h00));
        e_flag  = br_r | pend_m[k];
        e_addr  = br_r ? bt_r : paddr_m[k];
        e_flush = e_flag & ~e_stall[0];

        chk($sformatf("w%0d stall", mw),       {26'h0, o_stall[k]}, {26'h0, e_stall});
        chk($sformatf("w%0d branch_flag", mw), {31'h0, o_flag[k]},  {31'h0, e_flag});
        chk($sformatf("w%0d branch_addr", mw), o_addr[k],           e_addr);
        chk($sformatf("w%0d flush", mw),       {31'h0, o_flush[k]}, {31'h0, e_flush});
        chk($sformatf("w%0d mem_busy", mw),    {31'h0, o_busy[k]},  {31'h0, m_busy});
        chk($sformatf("w%0d stall_count", mw), o_cnt[k],            cnt_m[k]);

        if (e_flag) begin
          if (e_stall[0]) begin
            pend_m[k]  = 1'b1;
            paddr_m[k] = e_addr;
          end else begin
            pend_m[k]  = 1'b0;
          end
        end
        if (e_stall[0] && cnt_m[k] != 32'hFFFF_FFFF) cnt_m[k] = cnt_m[k] + 32'd1;
      end
    end
    if (rst) mvld = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic id, input logic ex, input logic ms,
                      input logic br, input logic [31:0] bt);
    @(posedge clk);
    #1;
    rst = r; id_r = id; ex_r = ex; ms_r = ms; br_r = br; bt_r = bt;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset with every input high, then release everything
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    idle(1);
    chk("reset stall",       {26'h0, o_stall[2]}, 32'h0);
    chk("reset branch_flag", {31'h0, o_flag[2]},  32'h0);
    chk("reset branch_addr", o_addr[2],           32'h0);
    chk("reset flush",       {31'h0, o_flush[2]}, 32'h0);
    chk("reset mem_busy",    {31'h0, o_busy[2]},  32'h0);
    chk("reset stall_count", o_cnt[2],            32'h0);

    // Memory wait, W=3, mem_start held through DONE and one cycle beyond
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk($sformatf("memwait stall c%0d", i), {26'h0, o_stall[2]}, (i == 3) ? 32'h00 : 32'h1F);
      chk($sformatf("memwait busy c%0d", i),  {31'h0, o_busy[2]},  (i == 1 || i == 2) ? 32'h1 : 32'h0);
      if (i == 3) chk("memwait stall_count", o_cnt[2], 32'd3);
    end
    idle(4);

    // Priority
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("prio id+ex", {26'h0, o_stall[2]}, 32'h0F);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("prio id", {26'h0, o_stall[2]}, 32'h07);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("prio id+mem", {26'h0, o_stall[2]}, 32'h1F);
    idle(5);

    // Branch during a W=2 access
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
    chk("brstall c0 flag",  {31'h0, o_flag[1]},  32'h1);
    chk("brstall c0 addr",  o_addr[1],           32'h40);
    chk("brstall c0 flush", {31'h0, o_flush[1]}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("brstall c1 stall", {26'h0, o_stall[1]}, 32'h1F);
    chk("brstall c1 flag",  {31'h0, o_flag[1]},  32'h1);
    chk("brstall c1 addr",  o_addr[1],           32'h40);
    chk("brstall c1 flush", {31'h0, o_flush[1]}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("brstall done stall", {26'h0, o_stall[1]}, 32'h0);
    chk("brstall done flush", {31'h0, o_flush[1]}, 32'h1);
    chk("brstall done addr",  o_addr[1],           32'h40);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("brstall after flag",  {31'h0, o_flag[1]},  32'h0);
    chk("brstall after flush", {31'h0, o_flush[1]}, 32'h0);
    idle(4);

    // Overwrite of a pending redirect, W=3
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("overwrite stalled flush", {31'h0, o_flush[2]}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("overwrite flush", {31'h0, o_flush[2]}, 32'h1);
    chk("overwrite addr",  o_addr[2],           32'h200);
    idle(4);

    // Reset during S_WAIT with a redirect pending
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0055);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(1);
    chk("rstmid stall", {26'h0, o_stall[2]}, 32'h0);
    chk("rstmid flag",  {31'h0, o_flag[2]},  32'h0);
    chk("rstmid busy",  {31'h0, o_busy[2]},  32'h0);
    chk("rstmid count", o_cnt[2],            32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rstmid new access", {26'h0, o_stall[2]}, 32'h1F);
    idle(4);

    // Randomised traffic, checked by the model every cycle
    repeat (2000) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           $urandom);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
